uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter (8N1) among NREQ requesters.
- Each requester streams framed packets of bytes: valid/ready/last.
- Round-robin grant at packet boundaries. The grant stays locked until the requester's last byte is handed over.
- Sequences the transmitter through its send_en / send_busy handshake, one byte at a time. Sits between sensor/report formatters and uart_tx.

Parameters:
- NREQ, 2, number of requesters (2..8).
- BUSY_TIMEOUT, 15, cycles to wait for tx_send_busy to rise after a send_en pulse before flagging an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a byte on its data lane
- req_data  in  8*NREQ  byte lanes, lane i = bits [8i+7:8i]
- req_last  in  NREQ  byte on lane i is the last byte of its packet
- req_ready  out  NREQ  byte on lane i accepted this cycle
- grant_id  out  3  index of the current/last granted requester
- tx_send_en  out  1  one-cycle start pulse to uart_tx
- tx_send_data  out  8  byte to uart_tx; valid while tx_send_en is high
- tx_send_busy  in  1  uart_tx busy; rises the cycle after it samples send_en
- idle  out  1  no packet in progress and transmitter idle
- err_timeout  out  1  sticky; busy never rose within BUSY_TIMEOUT

Behaviour:
- Reset (rst_n low, asynchronous), all registered outputs cleared:
  - state=ARB, tx_send_en=0, tx_send_data=0, grant_id=NREQ-1 (so requester 0 wins first), req_ready=0, err_timeout=0, idle=1.
- Byte transfer: a byte moves when req_valid[g] && req_ready[g].
- req_ready is combinational: high only for lane grant_id, only in LOAD, only while tx_send_busy=0. All other lanes read 0.

States:
- ARB:
  - If any req_valid is set, grant the first set index searching from grant_id+1 with wrap modulo NREQ. Register grant_id and go to LOAD (1 cycle).
  - Otherwise stay in ARB with idle=1.
- LOAD:
  - On a transfer: register tx_send_en=1, tx_send_data=req_data lane g, pkt_last=req_last[g]; go to HANDOFF.
  - If req_valid[g]=0: stay in LOAD; the grant is held and the requester may stall mid-packet.
- HANDOFF: tx_send_en is high for exactly this one cycle, then returns to 0. Clear the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - When tx_send_busy=1, go to WAIT_LO.
  - When the counter reaches BUSY_TIMEOUT, set err_timeout and go to WAIT_LO.
  - Otherwise increment the counter.
- WAIT_LO: when tx_send_busy=0, go to ARB if pkt_last=1, else to LOAD.

Timing and boundary rules:
- Latency: byte accepted at cycle T gives tx_send_en at T+1. Back-to-back bytes are limited by the UART frame time (10 bit times) plus 3 controller cycles.
- idle=1 only in ARB with tx_send_busy=0.
- Byte with req_last=1 is the last byte of the packet; after it the grant re-arbitrates. A one-byte packet is legal.
- Simultaneous requests: grant by round-robin order relative to the previous grant_id. No requester is granted twice in a row while another is valid at the ARB decision.
- Requester withdrawing valid mid-packet: the grant is held indefinitely (no preemption).
- req_valid/req_data of a non-granted lane are ignored and never accepted.
- tx_send_busy already high on entering LOAD: req_ready stays 0 until it falls.
- Reset mid-packet: abort immediately and return to the reset values. Any byte already inside uart_tx completes on the line; the controller re-waits for busy low in LOAD.
- Width: grant_id is 3 bits regardless of NREQ; values ≥ NREQ never occur after the first grant.

Test Plan:
- Single requester, packet 0x41,0x42,0x0A (last on 0x0A) → three tx_send_en pulses carrying exactly those bytes in order. Each pulse comes ≥1 uart frame after the previous. idle returns to 1 after the third busy falls.
- NREQ=2, both valid from reset with 2-byte packets A:0x11,0x12 and B:0x21,0x22 → UART sends 0x11,0x12,0x21,0x22 with no interleaving. grant_id reads 0 then 1.
- Requester 0 re-requests immediately after its last byte while requester 1 is waiting → requester 1 granted next (fairness).
- Requester 0 drops valid after byte 1 of 3 for 1000 cycles while requester 1 is valid → no byte from requester 1 is sent until requester 0 finishes.
- tx_send_busy tied 0 → err_timeout set exactly BUSY_TIMEOUT+1 cycles after HANDOFF and stays set. The controller continues to the next byte.
- Assert rst_n low for 1 cycle during byte 2 of a packet → outputs return to reset values asynchronously. After release, the next packet starts with a clean send_en pulse once busy is low.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ packet streams share a single 8N1 uart_tx.
// Grants are held for a whole packet; bytes are handed over one at a time through send_en/send_busy.
module uart_tx_arbiter #(
   parameter int NREQ         = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [8*NREQ-1:0] req_data_i,
   input  logic [NREQ-1:0]   req_last_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [2:0]        grant_id_o,
   output logic              tx_send_en_o,
   output logic [7:0]        tx_send_data_o,
   input  logic              tx_send_busy_i,
   output logic              idle_o,
   output logic              err_timeout_o
);

   localparam int CW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      ST_ARB,
      ST_LOAD,
      ST_HANDOFF,
      ST_WAIT_HI,
      ST_WAIT_LO
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      grant_q, grant_d;
   logic            send_en_q, send_en_d;
   logic [7:0]      send_data_q, send_data_d;
   logic            pkt_last_q, pkt_last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   // Lanes padded out to the 3-bit grant space so grant_q can index them directly.
   logic [7:0]      valid_pad;
   logic [7:0]      last_pad;
   logic [7:0]      data_pad [8];

   for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NREQ) begin : g_lane
         assign valid_pad[gi] = req_valid_i[gi];
         assign last_pad[gi]  = req_last_i[gi];
         assign data_pad[gi]  = req_data_i[8*gi +: 8];
      end else begin : g_unused
         assign valid_pad[gi] = 1'b0;
         assign last_pad[gi]  = 1'b0;
         assign data_pad[gi]  = 8'h00;
      end
   end

   logic ready_ok;
   logic xfer;

   assign ready_ok = (state_q == ST_LOAD) && !tx_send_busy_i;
   assign xfer     = ready_ok && valid_pad[grant_q];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready_o[gi] = ready_ok && (grant_q == 3'(gi));
   end

   // Search starts one past the previous grant so nobody wins twice while another waits.
   logic       found;
   logic [2:0] pick;
   logic [3:0] idx4;

   always_comb begin
      found = 1'b0;
      pick  = grant_q;
      idx4  = 4'd0;
      for (int k = 1; k <= NREQ; k++) begin
         idx4 = {1'b0, grant_q} + 4'(k);
         if (idx4 >= 4'(NREQ)) begin
            idx4 = idx4 - 4'(NREQ);
         end
         if (!found && valid_pad[idx4[2:0]]) begin
            found = 1'b1;
            pick  = idx4[2:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      send_en_d   = 1'b0;
      send_data_d = send_data_q;
      pkt_last_d  = pkt_last_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      case (state_q)
         ST_ARB: begin
            if (found) begin
               grant_d = pick;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               send_en_d   = 1'b1;
               send_data_d = data_pad[grant_q];
               pkt_last_d  = last_pad[grant_q];
               state_d     = ST_HANDOFF;
            end
         end
         ST_HANDOFF: begin
            cnt_d   = '0;
            state_d = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (tx_send_busy_i) begin
               state_d = ST_WAIT_LO;
            end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = ST_WAIT_LO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_LO: begin
            if (!tx_send_busy_i) begin
               state_d = pkt_last_q ? ST_ARB : ST_LOAD;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ARB;
         grant_q     <= 3'(NREQ - 1);
         send_en_q   <= 1'b0;
         send_data_q <= 8'h00;
         pkt_last_q  <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         send_en_q   <= send_en_d;
         send_data_q <= send_data_d;
         pkt_last_q  <= pkt_last_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

   assign grant_id_o     = grant_q;
   assign tx_send_en_o   = send_en_q;
   assign tx_send_data_o = send_data_q;
   assign err_timeout_o  = err_q;
   assign idle_o         = (state_q == ST_ARB) && !tx_send_busy_i;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet vector table plus hand-built fairness,
// stall, busy-timeout and mid-packet reset sequences, against a simple uart_tx busy model.
module tb_uart_tx_arbiter;

   localparam int NREQ  = 2;
   localparam int BTO   = 15;
   localparam int FRAME = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [2:0]  grant_id;
   logic        tx_send_en;
   logic [7:0]  tx_send_data;
   logic        tx_send_busy;
   logic        idle;
   logic        err_timeout;

   uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BTO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_last_i     (req_last),
      .req_ready_o    (req_ready),
      .grant_id_o     (grant_id),
      .tx_send_en_o   (tx_send_en),
      .tx_send_data_o (tx_send_data),
      .tx_send_busy_i (tx_send_busy),
      .idle_o         (idle),
      .err_timeout_o  (err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: busy rises the cycle after send_en is sampled and lasts FRAME cycles.
   int busy_cnt = 0;
   bit busy_force_low = 1'b0;
   always @(posedge clk) begin
      if (busy_force_low)    busy_cnt <= 0;
      else if (tx_send_en)   busy_cnt <= FRAME;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_send_busy = (busy_cnt != 0);

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Requester lanes: {last, data} entries, popped on accepted handshakes.
   logic [8:0] lane_mem [2][64];
   int lane_wr [2];
   int lane_rd [2];

   task automatic push(input int lane, input logic [8:0] v);
      lane_mem[lane][lane_wr[lane]] = v;
      lane_wr[lane]++;
   endtask

   initial begin
      logic [1:0] xfer;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         xfer = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (xfer[i]) lane_rd[i]++;
            if (lane_rd[i] < lane_wr[i]) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = lane_mem[i][lane_rd[i]][7:0];
               req_last[i]        = lane_mem[i][lane_rd[i]][8];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
      end
   end

   // Monitor: log every send_en pulse and count protocol violations.
   logic [7:0] sent_data [128];
   logic [2:0] sent_gid  [128];
   int         sent_cyc  [128];
   int n_sent    = 0;
   int bad_ready = 0;
   int bad_pulse = 0;
   int bad_idle  = 0;
   int min_gap   = 1000000;
   int last_en   = -1;

   initial begin
      bit en_prev;
      en_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 2; i++)
               if (req_ready[i] && (grant_id != 3'(i))) bad_ready++;
            if ((req_ready != 2'b00) && tx_send_busy) bad_ready++;
            if (idle && tx_send_busy) bad_idle++;
            if (tx_send_en) begin
               if (en_prev) bad_pulse++;
               if (idle) bad_idle++;
               sent_data[n_sent] = tx_send_data;
               sent_gid[n_sent]  = grant_id;
               sent_cyc[n_sent]  = cyc;
               if (last_en >= 0 && !busy_force_low && (cyc - last_en) < min_gap)
                  min_gap = cyc - last_en;
               last_en = cyc;
               n_sent++;
            end
            en_prev = tx_send_en;
         end else begin
            en_prev = 1'b0;
         end
      end
   end

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (k < 5000 && !(idle && lane_rd[0] == lane_wr[0] && lane_rd[1] == lane_wr[1])) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_drained"},
            int'(idle && lane_rd[0] == lane_wr[0] && lane_rd[1] == lane_wr[1]), 1);
   endtask

   task automatic wait_sent(input string tag, input int n);
      int k;
      k = 0;
      while (k < 2000 && n_sent < n) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_sent_by_deadline"}, int'(n_sent >= n), 1);
   endtask

   // ex entries are {grant_id[2:0], byte[7:0]}.
   task automatic compare_seq(input string tag, input int base, input int ne,
                              input logic [10:0] ex [6]);
      check({tag, "_count"}, n_sent - base, ne);
      for (int j = 0; j < ne && j < n_sent - base; j++) begin
         check($sformatf("%s_byte%0d", tag, j), int'(sent_data[base + j]), int'(ex[j][7:0]));
         check($sformatf("%s_gid%0d", tag, j), int'(sent_gid[base + j]), int'(ex[j][10:8]));
      end
   endtask

   typedef struct {
      int          n0;
      logic [8:0]  l0 [4];
      int          n1;
      logic [8:0]  l1 [4];
      int          ne;
      logic [10:0] ex [6];
   } vec_t;

   vec_t vecs [6];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      int k;
      int cnt_en;
      logic [10:0] ex [6];

      vecs[0] = '{n0: 2, l0: '{9'h011, 9'h112, 9'h000, 9'h000},
                  n1: 2, l1: '{9'h021, 9'h122, 9'h000, 9'h000},
                  ne: 4, ex: '{11'h011, 11'h012, 11'h121, 11'h122, 11'h000, 11'h000}};
      vecs[1] = '{n0: 3, l0: '{9'h041, 9'h042, 9'h10A, 9'h000},
                  n1: 0, l1: '{9'h000, 9'h000, 9'h000, 9'h000},
                  ne: 3, ex: '{11'h041, 11'h042, 11'h00A, 11'h000, 11'h000, 11'h000}};
      vecs[2] = '{n0: 0, l0: '{9'h000, 9'h000, 9'h000, 9'h000},
                  n1: 1, l1: '{9'h155, 9'h000, 9'h000, 9'h000},
                  ne: 1, ex: '{11'h155, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000}};
      vecs[3] = '{n0: 1, l0: '{9'h101, 9'h000, 9'h000, 9'h000},
                  n1: 1, l1: '{9'h102, 9'h000, 9'h000, 9'h000},
                  ne: 2, ex: '{11'h001, 11'h102, 11'h000, 11'h000, 11'h000, 11'h000}};
      vecs[4] = '{n0: 1, l0: '{9'h1E0, 9'h000, 9'h000, 9'h000},
                  n1: 0, l1: '{9'h000, 9'h000, 9'h000, 9'h000},
                  ne: 1, ex: '{11'h0E0, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000}};
      vecs[5] = '{n0: 2, l0: '{9'h0C1, 9'h1C2, 9'h000, 9'h000},
                  n1: 1, l1: '{9'h1D1, 9'h000, 9'h000, 9'h000},
                  ne: 3, ex: '{11'h1D1, 11'h0C1, 11'h0C2, 11'h000, 11'h000, 11'h000}};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_grant_id", int'(grant_id), NREQ - 1);
      check("rst_send_en", int'(tx_send_en), 0);
      check("rst_send_data", int'(tx_send_data), 0);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_err", int'(err_timeout), 0);
      check("rst_idle", int'(idle), 1);

      foreach (vecs[v]) begin
         base = n_sent;
         for (int j = 0; j < vecs[v].n0; j++) push(0, vecs[v].l0[j]);
         for (int j = 0; j < vecs[v].n1; j++) push(1, vecs[v].l1[j]);
         drain($sformatf("vec%0d", v));
         compare_seq($sformatf("vec%0d", v), base, vecs[v].ne, vecs[v].ex);
      end
      check("no_timeout_with_busy", int'(err_timeout), 0);

      // Fairness: lane 1 arrives during lane 0's packet; lane 0 re-requests right after.
      base = n_sent;
      push(0, 9'h031); push(0, 9'h132); push(0, 9'h133);
      wait_sent("fair", base + 1);
      push(1, 9'h171);
      drain("fair");
      ex = '{11'h031, 11'h032, 11'h171, 11'h033, 11'h000, 11'h000};
      compare_seq("fair", base, 4, ex);

      // Stall: lane 0 goes quiet mid-packet for 1000 cycles; grant must not move.
      base = n_sent;
      push(0, 9'h061);
      wait_sent("stall", base + 1);
      push(1, 9'h181);
      repeat (1000) @(negedge clk);
      check("stall_nothing_sent", n_sent - base, 1);
      check("stall_grant_held", int'(grant_id), 0);
      check("stall_lane1_not_ready", int'(req_ready[1]), 0);
      push(0, 9'h062); push(0, 9'h163);
      drain("stall");
      ex = '{11'h061, 11'h062, 11'h063, 11'h181, 11'h000, 11'h000};
      compare_seq("stall", base, 4, ex);
      check("min_byte_spacing", min_gap, FRAME + 3);

      // Busy never rises: 16 WAIT_HI cycles follow the send_en cycle, then the flag sets.
      busy_force_low = 1'b1;
      base = n_sent;
      push(1, 9'h091); push(1, 9'h192);
      k = 0;
      while (k < 200 && !tx_send_en) begin
         @(negedge clk);
         k++;
      end
      check("tmo_first_pulse", int'(tx_send_en), 1);
      for (int j = 1; j <= BTO + 2; j++) begin
         @(negedge clk);
         if (j == BTO + 1) check("tmo_err_not_yet", int'(err_timeout), 0);
         if (j == BTO + 2) check("tmo_err_set", int'(err_timeout), 1);
      end
      drain("tmo");
      busy_force_low = 1'b0;
      ex = '{11'h191, 11'h192, 11'h000, 11'h000, 11'h000, 11'h000};
      compare_seq("tmo", base, 2, ex);
      repeat (5) @(negedge clk);
      check("tmo_err_sticky", int'(err_timeout), 1);

      // Reset pulse while byte 2 is on the line.
      base = n_sent;
      push(0, 9'h0A1); push(0, 9'h0A2); push(0, 9'h1A3);
      cnt_en = 0;
      k = 0;
      while (k < 500 && cnt_en < 2) begin
         @(negedge clk);
         k++;
         if (tx_send_en) cnt_en++;
      end
      check("rstm_two_pulses", cnt_en, 2);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstm_send_en", int'(tx_send_en), 0);
      check("rstm_send_data", int'(tx_send_data), 0);
      check("rstm_req_ready", int'(req_ready), 0);
      check("rstm_grant_id", int'(grant_id), NREQ - 1);
      check("rstm_err_cleared", int'(err_timeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drain("rstm");
      ex = '{11'h0A1, 11'h0A2, 11'h0A3, 11'h000, 11'h000, 11'h000};
      compare_seq("rstm", base, 3, ex);
      if (n_sent - base >= 3)
         check("rstm_waits_busy_low",
               int'((sent_cyc[base + 2] - sent_cyc[base + 1]) >= FRAME + 2), 1);

      check("ready_only_granted_lane", bad_ready, 0);
      check("send_en_single_cycle", bad_pulse, 0);
      check("idle_consistency", bad_idle, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
